// File: rtl/mcif_wr_cpl_pkg.sv
// Shared types and constants for the MCIF write-completion tracker.
package mcif_wr_cpl_pkg;
   localparam int THREAD_ID_W   = 3;
   localparam int MAX_THREADS   = 8;
   localparam int CQ_PD_W       = 3;
   localparam int CQ_PD_ACK_BIT = 0;
   localparam int CQ_PD_LEN_LSB = 1;
   localparam int CQ_PD_LEN_MSB = 2;

   typedef struct packed {
      logic [1:0] len;
      logic       require_ack;
   } cpl_ctx_t;

   function automatic cpl_ctx_t pd_to_ctx(input logic [CQ_PD_W-1:0] pd);
      cpl_ctx_t ctx;
      ctx.len         = pd[CQ_PD_LEN_MSB:CQ_PD_LEN_LSB];
      ctx.require_ack = pd[CQ_PD_ACK_BIT];
      return ctx;
   endfunction
endpackage

// File: rtl/mcif_wr_cpl_tq.sv
// Single-thread context FIFO with occupancy count, full/empty and push/pop.
module mcif_wr_cpl_tq
   import mcif_wr_cpl_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic     i_clk,
   input  logic     i_rst,
   input  logic     i_push,
   input  cpl_ctx_t i_push_ctx,
   input  logic     i_pop,
   output cpl_ctx_t o_head,
   output logic     o_full,
   output logic     o_empty
);
   localparam int AW = $clog2(DEPTH);

   cpl_ctx_t       r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic           w_do_push;
   logic           w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == {(AW+1){1'b0}});
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   // Storage needs no reset: only entries below the count are ever read.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_ctx;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/nv_nvdla_mcif_write_eg_cpl.sv
// MCIF write egress completion tracker: per-thread context queues retired by AXI B.
// Optional sticky protocol-error flag cpl_err under MCIF_WR_CPL_ERR_CHK_EN.
module nv_nvdla_mcif_write_eg_cpl
   import mcif_wr_cpl_pkg::*;
#(
   parameter int NUM_THREADS = 5,
   parameter int CQ_DEPTH    = 16
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rst,
   input  logic                   cq_wr_pvld,
   output logic                   cq_wr_prdy,
   input  logic [2:0]             cq_wr_thread_id,
   input  logic [2:0]             cq_wr_pd,
   input  logic                   noc2mcif_axi_b_bvalid,
   output logic                   noc2mcif_axi_b_bready,
   input  logic [7:0]             noc2mcif_axi_b_bid,
   output logic                   eg2ig_axi_vld,
   output logic [1:0]             eg2ig_axi_len,
   output logic [NUM_THREADS-1:0] mcif2client_wr_rsp_complete
`ifdef MCIF_WR_CPL_ERR_CHK_EN
   ,
   output logic                   cpl_err
`endif
);
   logic [MAX_THREADS-1:0]  w_full;
   logic [MAX_THREADS-1:0]  w_empty;
   cpl_ctx_t                w_head [MAX_THREADS];
   logic [NUM_THREADS-1:0]  w_cpl_nxt;
   logic [2:0]              w_b_tid;
   logic                    w_push_fire;
   logic                    w_pop_ok;
   cpl_ctx_t                w_pop_head;
   logic                    w_unused_bid;
   logic                    r_vld;
   logic [1:0]              r_len;
   logic [NUM_THREADS-1:0]  r_cpl;

   assign noc2mcif_axi_b_bready = 1'b1;
   assign w_unused_bid          = ^noc2mcif_axi_b_bid[7:3];
   assign w_b_tid               = noc2mcif_axi_b_bid[THREAD_ID_W-1:0];

   // Unused thread slots read as never-full and always-empty, so out-of-range
   // pushes are accepted and out-of-range B beats never pop.
   assign cq_wr_prdy  = !w_full[cq_wr_thread_id];
   assign w_push_fire = cq_wr_pvld && cq_wr_prdy;
   assign w_pop_ok    = noc2mcif_axi_b_bvalid && !w_empty[w_b_tid];
   assign w_pop_head  = w_head[w_b_tid];

   for (genvar t = 0; t < MAX_THREADS; t++) begin : g_thr
      if (t < NUM_THREADS) begin : g_q
         mcif_wr_cpl_tq #(.DEPTH(CQ_DEPTH)) u_tq (
            .i_clk      (nvdla_core_clk),
            .i_rst      (nvdla_core_rst),
            .i_push     (w_push_fire && (cq_wr_thread_id == 3'(t))),
            .i_push_ctx (pd_to_ctx(cq_wr_pd)),
            .i_pop      (w_pop_ok && (w_b_tid == 3'(t))),
            .o_head     (w_head[t]),
            .o_full     (w_full[t]),
            .o_empty    (w_empty[t])
         );
      end else begin : g_pad
         assign w_full[t]  = 1'b0;
         assign w_empty[t] = 1'b1;
         assign w_head[t]  = cpl_ctx_t'(3'b000);
      end
   end

   always_comb begin
      w_cpl_nxt = {NUM_THREADS{1'b0}};
      if (w_pop_ok && w_pop_head.require_ack) begin
         w_cpl_nxt = NUM_THREADS'(1) << w_b_tid;
      end else begin
         w_cpl_nxt = {NUM_THREADS{1'b0}};
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         r_vld <= 1'b0;
         r_len <= 2'b00;
         r_cpl <= {NUM_THREADS{1'b0}};
      end else begin
         r_vld <= w_pop_ok;
         r_cpl <= w_cpl_nxt;
         if (w_pop_ok) begin
            r_len <= w_pop_head.len;
         end
      end
   end

   assign eg2ig_axi_vld               = r_vld;
   assign eg2ig_axi_len               = r_len;
   assign mcif2client_wr_rsp_complete = r_cpl;

`ifdef MCIF_WR_CPL_ERR_CHK_EN
   logic w_unexp;
   logic r_err;

   assign w_unexp = (noc2mcif_axi_b_bvalid && w_empty[w_b_tid])
                 || (w_push_fire && (32'(cq_wr_thread_id) >= NUM_THREADS));

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         r_err <= 1'b0;
      end else if (w_unexp) begin
         r_err <= 1'b1;
      end
   end

   assign cpl_err = r_err;
`endif
endmodule

// File: tb/tb_nv_nvdla_mcif_write_eg_cpl.sv
// Self-checking bench: directed vector table plus randomized traffic vs. a queue model.
module tb_nv_nvdla_mcif_write_eg_cpl;
   localparam int NT    = 5;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          pvld;
   logic          prdy;
   logic [2:0]    tid;
   logic [2:0]    pd;
   logic          bvalid;
   logic          bready;
   logic [7:0]    bid;
   logic          eg_vld;
   logic [1:0]    eg_len;
   logic [NT-1:0] cpl;
`ifdef MCIF_WR_CPL_ERR_CHK_EN
   logic          cpl_err;
`endif

   always #5 clk = ~clk;

   nv_nvdla_mcif_write_eg_cpl #(.NUM_THREADS(NT), .CQ_DEPTH(DEPTH)) dut (
      .nvdla_core_clk              (clk),
      .nvdla_core_rst              (rst),
      .cq_wr_pvld                  (pvld),
      .cq_wr_prdy                  (prdy),
      .cq_wr_thread_id             (tid),
      .cq_wr_pd                    (pd),
      .noc2mcif_axi_b_bvalid       (bvalid),
      .noc2mcif_axi_b_bready       (bready),
      .noc2mcif_axi_b_bid          (bid),
      .eg2ig_axi_vld               (eg_vld),
      .eg2ig_axi_len               (eg_len),
      .mcif2client_wr_rsp_complete (cpl)
`ifdef MCIF_WR_CPL_ERR_CHK_EN
      ,
      .cpl_err                     (cpl_err)
`endif
   );

   typedef struct {
      bit       rst;
      bit       pv;
      bit [2:0] tid;
      bit [2:0] pd;
      bit       bv;
      bit [7:0] bid;
      bit       e_prdy;
      bit       e_vld;
      bit [1:0] e_len;
      bit [4:0] e_cpl;
   } vec_t;

   vec_t      tbl[$];
   bit [2:0]  mq[8][$];   // model: per-thread queue of raw pd values
   bit        m_prdy;
   bit        m_vld;
   bit [1:0]  m_len;
   bit [4:0]  m_cpl;
   bit        m_err;
   int        checks = 0;
   int        errors = 0;

   function automatic vec_t mk(bit r, bit p, bit [2:0] t, bit [2:0] d, bit b, bit [7:0] i,
                               bit ep, bit ev, bit [1:0] el, bit [4:0] ec);
      vec_t v;
      v.rst = r; v.pv = p; v.tid = t; v.pd = d; v.bv = b; v.bid = i;
      v.e_prdy = ep; v.e_vld = ev; v.e_len = el; v.e_cpl = ec;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mq[i].delete();
      m_vld = 1'b0; m_len = 2'd0; m_cpl = 5'd0; m_err = 1'b0;
   endtask

   task automatic step(input vec_t v, input bit use_tbl);
      int  t;
      bit  pop;
      bit [2:0] h;
      @(negedge clk);
      rst = v.rst; pvld = v.pv; tid = v.tid; pd = v.pd; bvalid = v.bv; bid = v.bid;
      #2;
      m_prdy = (v.tid >= NT) ? 1'b1 : (mq[v.tid].size() < DEPTH);
      check("prdy", prdy, m_prdy);
      if (use_tbl) check("tbl_prdy", prdy, v.e_prdy);
      if (v.rst) begin
         model_reset();
      end else begin
         t   = int'(v.bid[2:0]);
         pop = v.bv && (t < NT) && (mq[t].size() > 0);
         if (v.bv && !pop) m_err = 1'b1;
         if (v.pv && v.tid >= NT) m_err = 1'b1;
         m_vld = pop;
         m_cpl = 5'd0;
         if (pop) begin
            h = mq[t].pop_front();
            m_len = h[2:1];
            if (h[0]) m_cpl[t] = 1'b1;
         end
         if (v.pv && m_prdy && v.tid < NT) mq[v.tid].push_back(v.pd);
      end
      @(posedge clk);
      #1;
      check("vld", eg_vld, m_vld);
      check("len", eg_len, m_len);
      check("cpl", cpl, m_cpl);
`ifdef MCIF_WR_CPL_ERR_CHK_EN
      check("cpl_err", cpl_err, m_err);
`endif
      if (use_tbl) begin
         check("tbl_vld", eg_vld, v.e_vld);
         check("tbl_len", eg_len, v.e_len);
         check("tbl_cpl", cpl, v.e_cpl);
      end
   endtask

   initial begin
      vec_t rv;
      rst = 1'b1; pvld = 1'b0; tid = 3'd0; pd = 3'd0; bvalid = 1'b0; bid = 8'd0;
      model_reset();
      @(posedge clk);
      #1;

      // reset state, single ack burst on thread 2
      tbl.push_back(mk(1'b1, 1'b0, 3'd0, 3'b000, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd2, 3'b101, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd2, 1'b1, 1'b1, 2'd2, 5'b00100));
      // thread 0 ordering without ack
      tbl.push_back(mk(1'b0, 1'b1, 3'd0, 3'b000, 1'b0, 8'd0, 1'b1, 1'b0, 2'd2, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd0, 3'b010, 1'b0, 8'd0, 1'b1, 1'b0, 2'd2, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd0, 3'b110, 1'b0, 8'd0, 1'b1, 1'b0, 2'd2, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd0, 1'b1, 1'b1, 2'd0, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd0, 1'b1, 1'b1, 2'd1, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd0, 1'b1, 1'b1, 2'd3, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b0, 8'd0, 1'b1, 1'b0, 2'd3, 5'b00000));
      // fill thread 1, full refusal, other thread unaffected, refusal during pop
      for (int i = 0; i < DEPTH; i++)
         tbl.push_back(mk(1'b0, 1'b1, 3'd1, 3'b011, 1'b0, 8'd0, 1'b1, 1'b0, 2'd3, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd1, 3'b011, 1'b0, 8'd0, 1'b0, 1'b0, 2'd3, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd3, 3'b001, 1'b0, 8'd0, 1'b1, 1'b0, 2'd3, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd1, 3'b011, 1'b1, 8'd1, 1'b0, 1'b1, 2'd1, 5'b00010));
      tbl.push_back(mk(1'b0, 1'b1, 3'd1, 3'b101, 1'b0, 8'd0, 1'b1, 1'b0, 2'd1, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd1, 3'b101, 1'b0, 8'd0, 1'b0, 1'b0, 2'd1, 5'b00000));
      // thread 4 simultaneous push/pop, then empty-queue B, out-of-range B and push
      tbl.push_back(mk(1'b0, 1'b1, 3'd4, 3'b001, 1'b0, 8'd0, 1'b1, 1'b0, 2'd1, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd4, 3'b111, 1'b1, 8'd4, 1'b1, 1'b1, 2'd0, 5'b10000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd4, 1'b1, 1'b1, 2'd3, 5'b10000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd4, 1'b1, 1'b0, 2'd3, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'hE6, 1'b1, 1'b0, 2'd3, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd7, 3'b111, 1'b0, 8'd0, 1'b1, 1'b0, 2'd3, 5'b00000));
      // reset with entries outstanding
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1'b0, 1'b1, 3'd2, 3'b111, 1'b0, 8'd0, 1'b1, 1'b0, 2'd3, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd2, 1'b1, 1'b1, 2'd3, 5'b00100));
      tbl.push_back(mk(1'b1, 1'b0, 3'd0, 3'b000, 1'b1, 8'd2, 1'b1, 1'b0, 2'd0, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b0, 3'd0, 3'b000, 1'b1, 8'd2, 1'b1, 1'b0, 2'd0, 5'b00000));
      tbl.push_back(mk(1'b0, 1'b1, 3'd1, 3'b011, 1'b0, 8'd0, 1'b1, 1'b0, 2'd0, 5'b00000));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);

      // randomized traffic, biased toward threads 0/1 so queues reach full
      for (int i = 0; i < 3000; i++) begin
         rv.rst = ($urandom_range(0, 999) == 0);
         rv.pv  = ($urandom_range(0, 99) < 60);
         rv.tid = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
         rv.pd  = 3'($urandom);
         rv.bv  = ($urandom_range(0, 99) < 45);
         rv.bid = 8'($urandom);
         if ($urandom_range(0, 3) != 0) rv.bid[2:0] = 3'($urandom_range(0, 1));
         rv.e_prdy = 1'b0; rv.e_vld = 1'b0; rv.e_len = 2'd0; rv.e_cpl = 5'd0;
         step(rv, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
